cam_line_centroid: RTL and testbench
====================================

// Module: cam_line_centroid
// PURPOSE
//  Consumes the CLK-domain pixel stream from ov7725 (cap_dout/cap_addr_x/cap_addr_y/cap_en, RGB565 QVGA)
//  and, per frame, computes the mean x of dark pixels inside a row band (line tracking for steering).
//  Luma conversion, thresholding and accumulation are pipelined; the end of the frame starts a sequential divider.
//  The result goes to the CPU-visible register block as a one-cycle valid pulse plus held values.
// PARAMETERS
//  IMG_W    320  pixels per line; the last pixel of a line has x == IMG_W-1
//  IMG_H    240  lines per frame; the last line has y == IMG_H-1
//  MIN_PIX  16   minimum dark-pixel count for cent_found=1
// PORTS
//  CLK         in   1   system clock
//  RST_X       in   1   reset, asynchronous, active-low
//  cap_dout    in   16  RGB565 pixel {R5,G6,B5}
//  cap_addr_x  in   10  pixel column
//  cap_addr_y  in   10  pixel row
//  cap_en      in   1   pixel valid, one pixel per cycle, no backpressure
//  thresh      in   8   a pixel is dark when luma < thresh (strictly less)
//  roi_top     in   10  first row of the band (inclusive)
//  roi_bot     in   10  last row of the band (inclusive); if roi_top > roi_bot, no pixel qualifies
//  cent_x      out  10  floor(sum_x / count) of the last found frame
//  cent_cnt    out  17  dark-pixel count of the last completed frame
//  cent_found  out  1   last completed frame had count >= MIN_PIX
//  cent_valid  out  1   1-cycle pulse when the outputs update
//  frame_drop  out  1   1-cycle pulse when a frame end is discarded because the divider is busy
// BEHAVIOUR
//  Reset: all outputs 0, accumulators 0, FSM in IDLE; async assert, sync deassert handled upstream.
//  S1 (cycle t+1 after cap_en):
//   - R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}
//   - Y=(2*R8+5*G8+B8)>>3, computed in 11 bits, range 0..255
//   - Register Y, x, y, sof=(x==0&&y==0), eof=(x==IMG_W-1&&y==IMG_H-1)
//  S2 (t+2):
//   - hit = Y<thresh && roi_top<=y<=roi_bot
//   - sof clears sum_x(25b) and cnt(17b) before this pixel's hit is added
//   - On hit: sum_x+=x, cnt+=1; no saturation is needed within IMG_W*IMG_H
//   - eof: snapshot the sums including this pixel into the divider, clear the accumulators that cycle; the next frame accumulates in parallel
//  FSM IDLE -> DIV -> DONE -> IDLE:
//   - IDLE: on eof snapshot, go to DIV
//   - DIV: restoring divide, 25 iterations, one quotient bit per cycle (t+3..t+27); skipped iterations are not allowed
//   - DONE (t+28): cent_valid=1 and cent_cnt=snapshot count
//   - If count>=MIN_PIX: cent_found=1 and cent_x=quotient[9:0]
//   - Else: cent_found=0 and cent_x is held unchanged; no divide-by-zero effect when the count is 0
//  eof while in DIV or DONE: that frame is discarded, frame_drop pulses at t+2, the accumulators are still cleared, the running divide is unaffected.
//  Missing eof (upstream FIFO overflow): no result; the next sof restarts accumulation cleanly.
//  thresh and roi_* are sampled in S2 of each pixel; a change mid-frame applies to subsequent pixels only.
//  RST_X asserted mid-DIV: divide aborted, no cent_valid, every output returns to 0.
// TESTING
//  T1 reset: hold RST_X=0 for 5 cycles -> all outputs 0; release, drive no pixels -> cent_valid never asserts.
//  T2 bar frame: white frame, black pixels at x=100..109 on rows 200..209, thresh=64, roi 200..209 -> cent_valid exactly 28 cycles after the cap_en of (319,239); cent_x=104, cent_cnt=100, cent_found=1.
//  T3 empty and low-count frames:
//   - All-white frame after T2 -> cent_cnt=0, cent_found=0, cent_x stays 104
//   - 15 dark pixels in the band -> cent_found=0
//  T4 luma edges:
//   - 16'h0000 with thresh=1 -> dark
//   - 16'hFFFF with thresh=255 -> not dark
//   - thresh=0 -> cnt=0
//   - roi_top=210, roi_bot=200 -> cnt=0
//  T5 partial frame: rows 0..99 with dark pixels, then a new sof and a full T2 frame -> result equals T2 exactly.
//  T6 overrun/reset:
//   - Second eof 10 cycles after the first -> frame_drop pulse, a single cent_valid from the first frame
//   - RST_X low at t+10 -> no cent_valid, outputs 0

Source files
------------

// File: rtl/cam_line_centroid_if.sv
// Pixel stream from the camera capture block: one RGB565 pixel per cycle
// with its column/row address, qualified by cap_en. There is no backpressure.
interface cam_line_centroid_if;
    logic [15:0] cap_dout;
    logic [9:0]  cap_addr_x;
    logic [9:0]  cap_addr_y;
    logic        cap_en;

    modport master (
        output cap_dout,
        output cap_addr_x,
        output cap_addr_y,
        output cap_en
    );

    modport slave (
        input  cap_dout,
        input  cap_addr_x,
        input  cap_addr_y,
        input  cap_en
    );
endinterface

// File: rtl/cam_line_centroid.sv
// Per-frame centroid of dark pixels inside a row band, for line tracking.
// Stage 1 converts RGB565 to 8-bit luma and flags start/end of frame,
// stage 2 thresholds and accumulates column sum and count, and the frame end
// hands a snapshot to a 25-step restoring divider whose result is published
// as held registers plus a one-cycle valid pulse.
module cam_line_centroid #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int MIN_PIX = 16
) (
    input  logic               CLK,
    input  logic               RST_X,
    cam_line_centroid_if.slave pix_if,
    input  logic [7:0]         thresh,
    input  logic [9:0]         roi_top,
    input  logic [9:0]         roi_bot,
    output logic [9:0]         cent_x,
    output logic [16:0]        cent_cnt,
    output logic               cent_found,
    output logic               cent_valid,
    output logic               frame_drop
);

    localparam logic [9:0]  X_LAST   = 10'(IMG_W - 1);
    localparam logic [9:0]  Y_LAST   = 10'(IMG_H - 1);
    localparam logic [16:0] MIN_CNT  = 17'(MIN_PIX);
    localparam logic [4:0]  DIV_LAST = 5'd24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Luma approximation Y = (2R + 5G + B) / 8 on bit-replicated 8-bit channels.
    function automatic logic [7:0] luma8(input logic [15:0] px);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [10:0] acc;
        r8  = {px[15:11], px[15:13]};
        g8  = {px[10:5], px[10:9]};
        b8  = {px[4:0], px[4:2]};
        acc = {2'b00, r8, 1'b0} + ({3'b000, g8} * 11'd5) + {3'b000, b8};
        return 8'(acc >> 3);
    endfunction

    // Stage 1 registers
    logic        v1_d, v1_q;
    logic [7:0]  luma1_d, luma1_q;
    logic [9:0]  x1_d, x1_q;
    logic [9:0]  row1_d, row1_q;
    logic        sof1_d, sof1_q;
    logic        eof1_d, eof1_q;

    // Stage 2 accumulators
    logic [24:0] sum_d, sum_q;
    logic [16:0] cnt_d, cnt_q;
    logic        hit_s;
    logic        eof_s;
    logic [24:0] new_sum_s;
    logic [16:0] new_cnt_s;

    // Divider and result registers
    state_t      state_d, state_q;
    logic [4:0]  iter_d, iter_q;
    logic [16:0] rem_d, rem_q;
    logic [24:0] quo_d, quo_q;
    logic [16:0] dvs_d, dvs_q;
    logic [16:0] snap_cnt_d, snap_cnt_q;
    logic [17:0] shifted_s;
    logic [9:0]  cent_x_d, cent_x_q;
    logic [16:0] cent_cnt_d, cent_cnt_q;
    logic        cent_found_d, cent_found_q;
    logic        cent_valid_d, cent_valid_q;
    logic        frame_drop_d, frame_drop_q;

    // Stage 1: luma conversion and frame-boundary flags for the incoming pixel.
    always_comb begin
        v1_d    = pix_if.cap_en;
        luma1_d = luma8(pix_if.cap_dout);
        x1_d    = pix_if.cap_addr_x;
        row1_d  = pix_if.cap_addr_y;
        sof1_d  = (pix_if.cap_addr_x == 10'd0) && (pix_if.cap_addr_y == 10'd0);
        eof1_d  = (pix_if.cap_addr_x == X_LAST) && (pix_if.cap_addr_y == Y_LAST);
    end

    // Stage 1 pipeline register.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            v1_q    <= 1'b0;
            luma1_q <= 8'd0;
            x1_q    <= 10'd0;
            row1_q  <= 10'd0;
            sof1_q  <= 1'b0;
            eof1_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            luma1_q <= luma1_d;
            x1_q    <= x1_d;
            row1_q  <= row1_d;
            sof1_q  <= sof1_d;
            eof1_q  <= eof1_d;
        end
    end

    // Stage 2: threshold/band test, accumulate; sof restarts, eof empties the accumulators.
    always_comb begin
        hit_s     = 1'b0;
        eof_s     = 1'b0;
        new_sum_s = sum_q;
        new_cnt_s = cnt_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        if (v1_q) begin
            hit_s = (luma1_q < thresh) && (row1_q >= roi_top) && (row1_q <= roi_bot);
            eof_s = eof1_q;
            if (sof1_q) begin
                new_sum_s = 25'd0;
                new_cnt_s = 17'd0;
            end else begin
                new_sum_s = sum_q;
                new_cnt_s = cnt_q;
            end
            if (hit_s) begin
                new_sum_s = new_sum_s + {15'd0, x1_q};
                new_cnt_s = new_cnt_s + 17'd1;
            end else begin
                new_sum_s = new_sum_s;
                new_cnt_s = new_cnt_s;
            end
            if (eof1_q) begin
                sum_d = 25'd0;
                cnt_d = 17'd0;
            end else begin
                sum_d = new_sum_s;
                cnt_d = new_cnt_s;
            end
        end else begin
            sum_d = sum_q;
            cnt_d = cnt_q;
        end
    end

    // Stage 2 accumulator registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sum_q <= 25'd0;
            cnt_q <= 17'd0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    // Divider FSM: accept a snapshot when idle, run all 25 quotient steps, publish in DONE.
    always_comb begin
        state_d      = state_q;
        iter_d       = iter_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        snap_cnt_d   = snap_cnt_q;
        cent_x_d     = cent_x_q;
        cent_cnt_d   = cent_cnt_q;
        cent_found_d = cent_found_q;
        cent_valid_d = 1'b0;
        frame_drop_d = 1'b0;
        shifted_s    = {rem_q, quo_q[24]};
        case (state_q)
            ST_IDLE: begin
                if (eof_s) begin
                    state_d    = ST_DIV;
                    iter_d     = 5'd0;
                    rem_d      = 17'd0;
                    quo_d      = new_sum_s;
                    dvs_d      = new_cnt_s;
                    snap_cnt_d = new_cnt_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                frame_drop_d = eof_s;
                // Dividend bits shift out of quo_q while quotient bits shift in.
                if (shifted_s >= {1'b0, dvs_q}) begin
                    rem_d = 17'(shifted_s - {1'b0, dvs_q});
                    quo_d = {quo_q[23:0], 1'b1};
                end else begin
                    rem_d = shifted_s[16:0];
                    quo_d = {quo_q[23:0], 1'b0};
                end
                if (iter_q == DIV_LAST) begin
                    state_d = ST_DONE;
                    iter_d  = 5'd0;
                end else begin
                    state_d = ST_DIV;
                    iter_d  = iter_q + 5'd1;
                end
            end
            ST_DONE: begin
                frame_drop_d = eof_s;
                cent_valid_d = 1'b1;
                cent_cnt_d   = snap_cnt_q;
                if (snap_cnt_q >= MIN_CNT) begin
                    cent_found_d = 1'b1;
                    cent_x_d     = quo_q[9:0];
                end else begin
                    cent_found_d = 1'b0;
                    cent_x_d     = cent_x_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Divider state, operands and registered result outputs.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q      <= ST_IDLE;
            iter_q       <= 5'd0;
            rem_q        <= 17'd0;
            quo_q        <= 25'd0;
            dvs_q        <= 17'd0;
            snap_cnt_q   <= 17'd0;
            cent_x_q     <= 10'd0;
            cent_cnt_q   <= 17'd0;
            cent_found_q <= 1'b0;
            cent_valid_q <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            snap_cnt_q   <= snap_cnt_d;
            cent_x_q     <= cent_x_d;
            cent_cnt_q   <= cent_cnt_d;
            cent_found_q <= cent_found_d;
            cent_valid_q <= cent_valid_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign cent_x     = cent_x_q;
    assign cent_cnt   = cent_cnt_q;
    assign cent_found = cent_found_q;
    assign cent_valid = cent_valid_q;
    assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_cam_line_centroid.sv
// Self-checking bench for cam_line_centroid: directed frames plus random
// frames, checked against a frame-level reference model (luma by plain
// arithmetic, sums/counts per frame, expected result/drop times queued).
module tb_cam_line_centroid;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic [7:0]  thresh;
    logic [9:0]  roi_top;
    logic [9:0]  roi_bot;
    logic [9:0]  cent_x;
    logic [16:0] cent_cnt;
    logic        cent_found;
    logic        cent_valid;
    logic        frame_drop;

    cam_line_centroid_if pif();

    cam_line_centroid dut (
        .CLK        (CLK),
        .RST_X      (RST_X),
        .pix_if     (pif),
        .thresh     (thresh),
        .roi_top    (roi_top),
        .roi_bot    (roi_bot),
        .cent_x     (cent_x),
        .cent_cnt   (cent_cnt),
        .cent_found (cent_found),
        .cent_valid (cent_valid),
        .frame_drop (frame_drop)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec   = 0;
    int n_err   = 0;
    int n_valid = 0;
    int n_drop  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        int cnt;
        int found;
        int x;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];
    int   m_sum    = 0;
    int   m_cnt    = 0;
    int   m_held_x = 0;
    int   k_busy   = -1000;
    int   last_k   = 0;

    function automatic int luma_ref(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return (2 * r + 5 * g + b) / 8;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        drop_q.delete();
        m_sum    = 0;
        m_cnt    = 0;
        m_held_x = 0;
        k_busy   = -1000;
    endtask

    task automatic send_px(input int x, input int y, input logic [15:0] d);
        exp_t e;
        int   k;
        pif.cap_dout   = d;
        pif.cap_addr_x = 10'(x);
        pif.cap_addr_y = 10'(y);
        pif.cap_en     = 1'b1;
        if (x == 0 && y == 0) begin
            m_sum = 0;
            m_cnt = 0;
        end
        if (luma_ref(d) < int'(thresh) && y >= int'(roi_top) && y <= int'(roi_bot)) begin
            m_sum += x;
            m_cnt++;
        end
        @(posedge CLK);
        #1;
        k = cyc;
        last_k = k;
        pif.cap_en = 1'b0;
        if (x == 319 && y == 239) begin
            if (k - k_busy < 27) begin
                drop_q.push_back(k + 1);
            end else begin
                k_busy = k;
                if (m_cnt >= 16) m_held_x = m_sum / m_cnt;
                e.cyc   = k + 27;
                e.cnt   = m_cnt;
                e.found = (m_cnt >= 16) ? 1 : 0;
                e.x     = m_held_x;
                exp_q.push_back(e);
            end
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_cfg(input int th, input int top, input int bot);
        idle(1);
        thresh  = 8'(th);
        roi_top = 10'(top);
        roi_bot = 10'(bot);
    endtask

    task automatic bar_frame();
        send_px(0, 0, WHITE);
        for (int r = 195; r < 215; r++) begin
            send_px(int'($urandom_range(0, 99)), r, WHITE);
            if (r >= 200 && r <= 209)
                for (int c = 100; c < 110; c++) send_px(c, r, BLACK);
            send_px(int'($urandom_range(110, 318)), r, WHITE);
        end
        send_px(319, 239, WHITE);
    endtask

    task automatic dark_frame(input int n, input int ylo, input int yhi, input logic [15:0] d);
        send_px(0, 0, WHITE);
        for (int i = 0; i < n; i++)
            send_px(int'($urandom_range(1, 318)), int'($urandom_range(ylo, yhi)), d);
        send_px(319, 239, WHITE);
        idle(30);
    endtask

    task automatic rand_frame();
        int n, t, b, x, y;
        logic [15:0] d;
        t = int'($urandom_range(0, 239));
        if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 239));
        else b = int'($urandom_range(t, 239));
        set_cfg(int'($urandom_range(0, 255)), t, b);
        send_px(0, 0, WHITE);
        n = int'($urandom_range(20, 80));
        for (int i = 0; i < n; i++) begin
            x = int'($urandom_range(1, 318));
            if (t <= b && $urandom_range(0, 3) != 0) y = int'($urandom_range(t, b));
            else y = int'($urandom_range(0, 238));
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d = d & 16'h3186;
            send_px(x, y, d);
            if ($urandom_range(0, 5) == 0) idle(1);
            if (i == n / 2 && $urandom_range(0, 1) == 1)
                set_cfg(int'($urandom_range(0, 255)), t, b);
        end
        send_px(319, 239, WHITE);
        idle(30);
    endtask

    // Result/drop monitor, sampled on the falling edge.
    exp_t me;
    int   md;
    always @(negedge CLK) begin
        if (RST_X) begin
            if (cent_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", 32'(cent_valid), 32'd0);
                end else begin
                    me = exp_q.pop_front();
                    chk("valid_cycle", cyc, me.cyc);
                    chk("cent_cnt", 32'(cent_cnt), me.cnt);
                    chk("cent_found", 32'(cent_found), me.found);
                    chk("cent_x", 32'(cent_x), me.x);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                me = exp_q.pop_front();
                chk("valid_missing", 32'(cent_valid), 32'd1);
            end
            if (frame_drop) begin
                n_drop++;
                if (drop_q.size() == 0) begin
                    chk("drop_unexpected", 32'(frame_drop), 32'd0);
                end else begin
                    md = drop_q.pop_front();
                    chk("drop_cycle", cyc, md);
                end
            end else if (drop_q.size() > 0 && cyc > drop_q[0]) begin
                md = drop_q.pop_front();
                chk("drop_missing", 32'(frame_drop), 32'd1);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, 32'(cent_x), 32'd0);
        chk({tag, "_cnt"}, 32'(cent_cnt), 32'd0);
        chk({tag, "_found"}, 32'(cent_found), 32'd0);
        chk({tag, "_valid"}, 32'(cent_valid), 32'd0);
        chk({tag, "_drop"}, 32'(frame_drop), 32'd0);
    endtask

    int v0;
    int d0;
    int g;

    initial begin
        pif.cap_en     = 1'b0;
        pif.cap_dout   = 16'd0;
        pif.cap_addr_x = 10'd0;
        pif.cap_addr_y = 10'd0;
        thresh         = 8'd64;
        roi_top        = 10'd200;
        roi_bot        = 10'd209;

        // T1: reset values, then no pixels -> no result
        RST_X = 1'b0;
        idle(5);
        chk_zero("t1_rst");
        RST_X = 1'b1;
        idle(40);
        chk("t1_no_valid", n_valid, 32'd0);

        // T2: bar frame, direct check at the exact result cycle
        bar_frame();
        idle(27);
        chk("t2_valid", 32'(cent_valid), 32'd1);
        chk("t2_x", 32'(cent_x), 32'd104);
        chk("t2_cnt", 32'(cent_cnt), 32'd100);
        chk("t2_found", 32'(cent_found), 32'd1);
        idle(5);

        // T3: empty frame keeps cent_x, then a 15-pixel frame is not found
        dark_frame(0, 200, 209, BLACK);
        chk("t3_hold_x", 32'(cent_x), 32'd104);
        chk("t3_empty_cnt", 32'(cent_cnt), 32'd0);
        dark_frame(15, 200, 209, BLACK);
        chk("t3_low_found", 32'(cent_found), 32'd0);
        chk("t3_low_cnt", 32'(cent_cnt), 32'd15);

        // T4: luma/threshold/band edges
        set_cfg(1, 0, 239);
        dark_frame(20, 0, 238, BLACK);
        chk("t4_black_dark", 32'(cent_cnt), 32'd20);
        set_cfg(255, 0, 239);
        dark_frame(20, 0, 238, WHITE);
        chk("t4_white_not_dark", 32'(cent_cnt), 32'd0);
        set_cfg(0, 0, 239);
        dark_frame(20, 0, 238, BLACK);
        chk("t4_thresh0", 32'(cent_cnt), 32'd0);
        set_cfg(64, 210, 200);
        dark_frame(20, 195, 215, BLACK);
        chk("t4_roi_inverted", 32'(cent_cnt), 32'd0);

        // T5: partial frame without eof, then a clean bar frame
        set_cfg(64, 0, 239);
        send_px(0, 0, WHITE);
        for (int i = 0; i < 60; i++)
            send_px(int'($urandom_range(1, 318)), int'($urandom_range(0, 99)), BLACK);
        set_cfg(64, 200, 209);
        bar_frame();
        idle(27);
        chk("t5_x", 32'(cent_x), 32'd104);
        chk("t5_cnt", 32'(cent_cnt), 32'd100);
        chk("t5_found", 32'(cent_found), 32'd1);
        idle(5);

        // T6a: second eof 10 cycles after the first is dropped
        v0 = n_valid;
        d0 = n_drop;
        set_cfg(64, 0, 239);
        send_px(0, 0, WHITE);
        for (int i = 0; i < 20; i++)
            send_px(int'($urandom_range(1, 318)), int'($urandom_range(0, 238)), BLACK);
        send_px(319, 239, WHITE);
        idle(9);
        send_px(319, 239, WHITE);
        idle(40);
        chk("t6_one_valid", n_valid - v0, 32'd1);
        chk("t6_one_drop", n_drop - d0, 32'd1);

        // T6b: reset in the middle of a divide
        v0 = n_valid;
        send_px(0, 0, WHITE);
        for (int i = 0; i < 20; i++)
            send_px(int'($urandom_range(1, 318)), int'($urandom_range(0, 238)), BLACK);
        send_px(319, 239, WHITE);
        idle(9);
        RST_X = 1'b0;
        #1;
        chk_zero("t6_rst");
        model_reset();
        idle(3);
        RST_X = 1'b1;
        idle(40);
        chk("t6_rst_no_valid", n_valid - v0, 32'd0);

        // Random frames
        for (int f = 0; f < 8; f++) rand_frame();

        // Back-to-back frame ends away from the busy boundary
        for (int p = 0; p < 4; p++) begin
            if (p[0]) g = int'($urandom_range(30, 38));
            else g = int'($urandom_range(12, 20));
            set_cfg(64, 0, 239);
            send_px(0, 0, WHITE);
            for (int i = 0; i < 20; i++)
                send_px(int'($urandom_range(1, 318)), int'($urandom_range(0, 238)), BLACK);
            send_px(319, 239, WHITE);
            idle(g - 1);
            send_px(319, 239, WHITE);
            idle(40);
        end

        idle(40);
        chk("pending_valid", 32'(exp_q.size()), 32'd0);
        chk("pending_drop", 32'(drop_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
